// File: rtl/fetch_ctrl.sv
// fetch_ctrl: F-stage PC sequencing controller.
// Chooses next-PC select, PC hold and pipeline flush each cycle.
module fetch_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       imem_ready,
  input  logic       hazard_stall,
  input  logic       d_branch_req,
  input  logic       d_jal_req,
  input  logic       d_jr_req,
  input  logic       m_exc_req,
  input  logic       m_eret_req,
  input  logic       md_start,
  input  logic       md_is_div,
  input  logic       d_md_use,
  output logic [2:0] next_pc_op,
  output logic       pc_stall,
  output logic       flush_fde,
  output logic       md_busy,
  output logic       pending_valid
);

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_e;

  typedef enum logic {
    K_ERET,
    K_EXC
  } kind_e;

  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_SEQ = 3'd0;
  localparam logic [2:0] OP_BR  = 3'd1;
  localparam logic [2:0] OP_JAL = 3'd2;
  localparam logic [2:0] OP_JR  = 3'd3;
  localparam logic [2:0] OP_EXC = 3'd4;
  localparam logic [2:0] OP_EPC = 3'd5;

  md_state_e  md_q, md_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pv_q, pv_d;
  kind_e      pk_q, pk_d;

  logic [3:0] ld_val;
  logic       eff_exc;
  logic       eff_eret;
  logic       md_hold;
  logic       s_wait;
  logic       s_exc;
  logic       s_eret;
  logic       s_hold;
  logic       s_run;

  assign ld_val  = md_is_div ? DIV_LD : MULT_LD;
  assign md_busy = (md_q == MD_BUSY);

  assign pending_valid = pv_q;

  assign eff_exc  = m_exc_req  | (pv_q & (pk_q == K_EXC));
  assign eff_eret = m_eret_req | (pv_q & (pk_q == K_ERET));
  assign md_hold  = d_md_use & (md_start | md_busy);

  // One-hot decision terms so the output decode is a flat select.
  assign s_wait = ~imem_ready;
  assign s_exc  = imem_ready & eff_exc;
  assign s_eret = imem_ready & ~eff_exc & eff_eret;
  assign s_hold = imem_ready & ~eff_exc & ~eff_eret
                & (hazard_stall | md_hold);
  assign s_run  = imem_ready & ~eff_exc & ~eff_eret
                & ~hazard_stall & ~md_hold;

  // State registers: mult/div tracker and pending redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_q  <= MD_IDLE;
      cnt_q <= '0;
      pv_q  <= 1'b0;
      pk_q  <= K_ERET;
    end else begin
      md_q  <= md_d;
      cnt_q <= cnt_d;
      pv_q  <= pv_d;
      pk_q  <= pk_d;
    end
  end

  // Mult/div busy tracker; a start while counting is ignored.
  always_comb begin
    md_d  = md_q;
    cnt_d = cnt_q;
    unique case (md_q)
      MD_IDLE: begin
        if (md_start) begin
          md_d  = MD_BUSY;
          cnt_d = ld_val;
        end
      end
      MD_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (md_start) begin
          cnt_d = ld_val;
        end else begin
          md_d = MD_IDLE;
        end
      end
      default: begin
        md_d  = MD_IDLE;
        cnt_d = '0;
      end
    endcase
  end

  // Pending entry: capture M requests while fetch is frozen.
  always_comb begin
    pv_d = pv_q;
    pk_d = pk_q;
    if (imem_ready) begin
      pv_d = 1'b0;
      pk_d = K_ERET;
    end else if (m_exc_req) begin
      pv_d = 1'b1;
      pk_d = K_EXC;
    end else if (m_eret_req && !pv_q) begin
      pv_d = 1'b1;
      pk_d = K_ERET;
    end
  end

  // Output resolution: memory wait, M redirects, stalls, D redirects.
  always_comb begin
    next_pc_op = OP_SEQ;
    pc_stall   = 1'b0;
    flush_fde  = 1'b0;
    unique case (1'b1)
      s_wait: begin
        pc_stall = 1'b1;
      end
      s_exc: begin
        next_pc_op = OP_EXC;
        flush_fde  = 1'b1;
      end
      s_eret: begin
        next_pc_op = OP_EPC;
        flush_fde  = 1'b1;
      end
      s_hold: begin
        pc_stall = 1'b1;
      end
      s_run: begin
        if (d_jr_req) begin
          next_pc_op = OP_JR;
        end else if (d_jal_req) begin
          next_pc_op = OP_JAL;
        end else if (d_branch_req) begin
          next_pc_op = OP_BR;
        end
      end
      default: begin
        pc_stall = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and random checks of fetch_ctrl
// against a cycle-level behavioural model.
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       imem_ready = 1'b0;
  logic       hazard_stall = 1'b0;
  logic       d_branch_req = 1'b0;
  logic       d_jal_req = 1'b0;
  logic       d_jr_req = 1'b0;
  logic       m_exc_req = 1'b0;
  logic       m_eret_req = 1'b0;
  logic       md_start = 1'b0;
  logic       md_is_div = 1'b0;
  logic       d_md_use = 1'b0;
  logic [2:0] next_pc_op;
  logic       pc_stall;
  logic       flush_fde;
  logic       md_busy;
  logic       pending_valid;

  int total = 0;
  int bad = 0;

  // model: remaining busy cycles, pending kind (0 none, 1 eret, 2 exc)
  int busy_left = 0;
  int pend = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_ready(imem_ready),
    .hazard_stall(hazard_stall),
    .d_branch_req(d_branch_req),
    .d_jal_req(d_jal_req),
    .d_jr_req(d_jr_req),
    .m_exc_req(m_exc_req),
    .m_eret_req(m_eret_req),
    .md_start(md_start),
    .md_is_div(md_is_div),
    .d_md_use(d_md_use),
    .next_pc_op(next_pc_op),
    .pc_stall(pc_stall),
    .flush_fde(flush_fde),
    .md_busy(md_busy),
    .pending_valid(pending_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    imem_ready   = 1'b1;
    hazard_stall = 1'b0;
    d_branch_req = 1'b0;
    d_jal_req    = 1'b0;
    d_jr_req     = 1'b0;
    m_exc_req    = 1'b0;
    m_eret_req   = 1'b0;
    md_start     = 1'b0;
    md_is_div    = 1'b0;
    d_md_use     = 1'b0;
  endtask

  task automatic check_outs(input string tag);
    int  e_op;
    int  e_st;
    int  e_fl;
    bit  ex;
    bit  er;
    ex   = m_exc_req || (pend == 2);
    er   = m_eret_req || (pend == 1);
    e_op = 0;
    e_st = 0;
    e_fl = 0;
    if (!imem_ready) begin
      e_st = 1;
    end else if (ex) begin
      e_op = 4;
      e_fl = 1;
    end else if (er) begin
      e_op = 5;
      e_fl = 1;
    end else if (hazard_stall ||
                 (d_md_use && (md_start || busy_left > 0))) begin
      e_st = 1;
    end else begin
      e_op = d_jr_req ? 3 : d_jal_req ? 2 : d_branch_req ? 1 : 0;
    end
    chk({tag, ".op"}, 32'(next_pc_op), 32'(e_op));
    chk({tag, ".stall"}, 32'(pc_stall), 32'(e_st));
    chk({tag, ".flush"}, 32'(flush_fde), 32'(e_fl));
    chk({tag, ".busy"}, 32'(md_busy), 32'(busy_left > 0));
    chk({tag, ".pend"}, 32'(pending_valid), 32'(pend != 0));
  endtask

  task automatic model_edge();
    if (!reset) begin
      busy_left = 0;
      pend = 0;
    end else begin
      if (md_start && busy_left <= 1)
        busy_left = md_is_div ? 10 : 5;
      else if (busy_left > 0)
        busy_left--;
      if (imem_ready)
        pend = 0;
      else if (m_exc_req)
        pend = 2;
      else if (m_eret_req && pend == 0)
        pend = 1;
    end
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    #1;
    check_outs(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic async_reset();
    reset = 1'b0;
    busy_left = 0;
    pend = 0;
    #1;
    chk("arst.busy", 32'(md_busy), 32'd0);
    chk("arst.pend", 32'(pending_valid), 32'd0);
    cycle("arst_low");
    reset = 1'b1;
  endtask

  initial begin
    idle_inputs();
    imem_ready = 1'b0;
    reset = 1'b0;
    #2;
    imem_ready = 1'b0;
    idle_inputs();
    imem_ready = 1'b0;
    chk("rst.op", 32'(next_pc_op), 32'd0);
    chk("rst.busy", 32'(md_busy), 32'd0);
    chk("rst.pend", 32'(pending_valid), 32'd0);
    chk("rst.flush", 32'(flush_fde), 32'd0);
    cycle("rst");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();
    for (int i = 0; i < 4; i++) cycle("idle");

    // divide, reset asserted in its 4th busy cycle
    md_start = 1'b1;
    md_is_div = 1'b1;
    cycle("div0");
    md_start = 1'b0;
    for (int i = 0; i < 3; i++) cycle("divr");
    async_reset();
    for (int i = 0; i < 3; i++) cycle("post_rst");

    // divide with dependent D instruction held
    d_md_use = 1'b1;
    md_start = 1'b1;
    md_is_div = 1'b1;
    cycle("divs");
    md_start = 1'b0;
    for (int i = 0; i < 12; i++) cycle("div");
    md_start = 1'b1;
    md_is_div = 1'b0;
    cycle("muls");
    md_start = 1'b0;
    for (int i = 0; i < 7; i++) cycle("mul");
    d_md_use = 1'b0;

    // D redirect priority, then hazard stall override
    d_jr_req = 1'b1;
    d_jal_req = 1'b1;
    d_branch_req = 1'b1;
    #1;
    chk("dir.jr", 32'(next_pc_op), 32'd3);
    cycle("dir");
    hazard_stall = 1'b1;
    #1;
    chk("dir.hz", 32'(pc_stall), 32'd1);
    cycle("dirhz");
    idle_inputs();

    // simultaneous exc and eret under a hazard stall
    hazard_stall = 1'b1;
    m_exc_req = 1'b1;
    m_eret_req = 1'b1;
    #1;
    chk("excer.op", 32'(next_pc_op), 32'd4);
    cycle("excer");
    m_exc_req = 1'b0;
    m_eret_req = 1'b0;
    for (int i = 0; i < 2; i++) cycle("excer_after");
    idle_inputs();

    // requests latched while imem is not ready
    imem_ready = 1'b0;
    cycle("hold0");
    m_eret_req = 1'b1;
    cycle("hold1");
    m_eret_req = 1'b0;
    m_exc_req = 1'b1;
    #1;
    chk("hold.pv", 32'(pending_valid), 32'd1);
    cycle("hold2");
    m_exc_req = 1'b0;
    cycle("hold3");
    imem_ready = 1'b1;
    #1;
    chk("rel.op", 32'(next_pc_op), 32'd4);
    cycle("rel");
    for (int i = 0; i < 2; i++) cycle("rel_after");

    // exception during a multiply does not cancel it
    md_start = 1'b1;
    md_is_div = 1'b0;
    cycle("mx0");
    md_start = 1'b0;
    cycle("mx1");
    cycle("mx2");
    m_exc_req = 1'b1;
    cycle("mx3");
    m_exc_req = 1'b0;
    for (int i = 0; i < 5; i++) cycle("mx");

    // back-to-back: restart in the final busy cycle
    md_start = 1'b1;
    cycle("bb0");
    md_start = 1'b0;
    for (int i = 0; i < 4; i++) cycle("bb");
    md_start = 1'b1;
    md_is_div = 1'b1;
    cycle("bb_re");
    md_start = 1'b0;
    for (int i = 0; i < 12; i++) cycle("bb2");

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      imem_ready   = ($urandom_range(0, 3) != 0);
      hazard_stall = ($urandom_range(0, 5) == 0);
      d_branch_req = $urandom_range(0, 1) == 1;
      d_jal_req    = ($urandom_range(0, 3) == 0);
      d_jr_req     = ($urandom_range(0, 3) == 0);
      m_exc_req    = ($urandom_range(0, 11) == 0);
      m_eret_req   = ($urandom_range(0, 9) == 0);
      d_md_use     = ($urandom_range(0, 2) == 0);
      md_is_div    = $urandom_range(0, 1) == 1;
      md_start     = (busy_left <= 1) && ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 249) == 0) async_reset();
      else cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
